// File: rtl/jpeg_dec_reorder_if.sv
// Coefficient-path bundle between the burst FIFO, the reorder stage and the IDCT.
//   slave  : reorder-stage side (consumes run-length entries, produces raster coefficients)
//   master : environment side (burst FIFO producer + IDCT consumer)
// Signals:
//   iPI_EN/iPI/iPI_DC/iPI_LST/iPI_ZR : run-length entry from the burst FIFO
//   oREORD_AFULL                      : backpressure to the burst FIFO
//   iIDCT_AFULL                       : backpressure from the IDCT
//   oCO_EN/oCO/oCO_IDX/oCO_LST        : raster-order coefficient stream
//   oERR                              : sticky protocol error
interface jpeg_dec_reorder_if;
  logic        iPI_EN;
  logic [11:0] iPI;
  logic        iPI_DC;
  logic        iPI_LST;
  logic [3:0]  iPI_ZR;
  logic        oREORD_AFULL;
  logic        iIDCT_AFULL;
  logic        oCO_EN;
  logic [11:0] oCO;
  logic [5:0]  oCO_IDX;
  logic        oCO_LST;
  logic        oERR;

  modport slave (
    input  iPI_EN, iPI, iPI_DC, iPI_LST, iPI_ZR, iIDCT_AFULL,
    output oREORD_AFULL, oCO_EN, oCO, oCO_IDX, oCO_LST, oERR
  );

  modport master (
    output iPI_EN, iPI, iPI_DC, iPI_LST, iPI_ZR, iIDCT_AFULL,
    input  oREORD_AFULL, oCO_EN, oCO, oCO_IDX, oCO_LST, oERR
  );
endinterface

// File: rtl/jpeg_dec_reorder.sv
// Zero-run expansion and de-zigzag stage of the JPEG decoder.
// Run-length entries land in a small skid FIFO, are expanded into one bank of a
// two-bank ping-pong 8x8 coefficient buffer, and completed banks are streamed to
// the IDCT in raster order with implicit zeros filled in from a written mask.
// Ports:
//   iCLK     : clock
//   iRSTN    : synchronous active-low reset
//   iINIT    : synchronous flush, same effect as reset
//   if_reord : coefficient-path bundle (slave side), see jpeg_dec_reorder_if
module jpeg_dec_reorder #(
  parameter int SKID_AW   = 2,
  parameter int AFULL_OFF = 2
) (
  input  logic              iCLK,
  input  logic              iRSTN,
  input  logic              iINIT,
  jpeg_dec_reorder_if.slave if_reord
);
  localparam int               DEPTH    = 1 << SKID_AW;
  localparam logic [SKID_AW:0] LP_DEPTH = DEPTH[SKID_AW:0];
  localparam logic [SKID_AW:0] LP_AOFF  = AFULL_OFF[SKID_AW:0];

  typedef enum logic [1:0] {B_FREE, B_FILL, B_FULL} bst_e;
  typedef enum logic [1:0] {W_WAIT, W_FILL, W_DROP} wst_e;
  typedef enum logic       {R_IDLE, R_RUN} rdst_e;

  typedef struct packed {
    logic [11:0] val;
    logic        dc;
    logic        lst;
    logic [3:0]  zr;
  } ent_t;

  localparam logic [5:0] ZZ2NAT [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // skid FIFO
  ent_t               r_fifo [DEPTH];
  logic [SKID_AW-1:0] r_wp, r_rp;
  logic [SKID_AW:0]   r_cnt, w_cnt_nxt;
  logic               w_push, w_ovf, w_pop, w_nemp;
  ent_t               w_head;
  logic               r_afull;

  // write side
  wst_e       r_wst, w_wst_nxt;
  logic [6:0] r_pos, w_pos_nxt, w_pos_eff, w_tz;
  logic       w_take, w_claim, w_done, w_wr, w_err;
  logic [5:0] w_nat;

  // banks
  bst_e             r_bst [2];
  logic             r_wsel, r_rsel;
  logic [1:0][63:0] r_mask;
  logic [11:0]      r_mem [2][64];

  // read side
  rdst_e      r_rdst, w_rdst_nxt;
  logic [5:0] r_ridx;
  logic       w_emit, w_free;

  // outputs
  logic        r_co_en, r_co_lst, r_err;
  logic [11:0] r_co;
  logic [5:0]  r_co_idx;

  assign w_nemp    = (r_cnt != '0);
  assign w_head    = r_fifo[r_rp];
  assign w_ovf     = if_reord.iPI_EN && (r_cnt == LP_DEPTH);
  assign w_push    = if_reord.iPI_EN && !w_ovf;
  assign w_cnt_nxt = r_cnt + {{SKID_AW{1'b0}}, w_push} - {{SKID_AW{1'b0}}, w_pop};

  // In WAIT the head entry is consumed in the same cycle the bank is claimed,
  // so the block starts at position 0 without a dead cycle.
  assign w_pos_eff = (r_wst == W_WAIT) ? 7'd0 : r_pos;
  assign w_tz      = w_pos_eff + {3'b000, w_head.zr};
  assign w_nat     = ZZ2NAT[w_tz[5:0]];

  always_comb begin
    w_wst_nxt = r_wst;
    w_pos_nxt = r_pos;
    w_take    = 1'b0;
    w_pop     = 1'b0;
    w_claim   = 1'b0;
    w_done    = 1'b0;
    w_wr      = 1'b0;
    w_err     = 1'b0;
    case (r_wst)
      W_WAIT: begin
        // claim sees the registered bank state, so a bank freed this cycle
        // becomes claimable only on the next one
        if (w_nemp && (r_bst[r_wsel] == B_FREE)) begin
          w_claim = 1'b1;
          w_take  = 1'b1;
        end
      end
      W_FILL: w_take = w_nemp;
      W_DROP: begin
        if (w_nemp) begin
          w_pop = 1'b1;
          if (w_head.lst) begin
            w_done    = 1'b1;
            w_wst_nxt = W_WAIT;
          end
        end
      end
      default: w_wst_nxt = W_WAIT;
    endcase

    if (w_take) begin
      w_pop = 1'b1;
      if ((w_tz > 7'd63) || (w_head.dc && (w_pos_eff != 7'd0)) ||
          (!w_head.dc && (w_pos_eff == 7'd0))) begin
        // bad entry is not stored; an LST on it closes the block right away
        w_err = 1'b1;
        if (w_head.lst) begin
          w_done    = 1'b1;
          w_wst_nxt = W_WAIT;
        end else begin
          w_wst_nxt = W_DROP;
        end
      end else begin
        w_wr      = 1'b1;
        w_pos_nxt = w_tz + 7'd1;
        if (w_head.lst) begin
          w_done    = 1'b1;
          w_wst_nxt = W_WAIT;
        end else if (w_tz == 7'd63) begin
          // position 63 filled but no EOB: the block overran
          w_err     = 1'b1;
          w_wst_nxt = W_DROP;
        end else begin
          w_wst_nxt = W_FILL;
        end
      end
    end
  end

  // r_ridx is 0 whenever the read side is idle, so IDLE can emit index 0
  // directly and back-to-back blocks leave no gap.
  always_comb begin
    w_rdst_nxt = r_rdst;
    w_emit     = 1'b0;
    w_free     = 1'b0;
    case (r_rdst)
      R_IDLE: begin
        if ((r_bst[r_rsel] == B_FULL) && !if_reord.iIDCT_AFULL) begin
          w_emit     = 1'b1;
          w_rdst_nxt = R_RUN;
        end
      end
      R_RUN: begin
        if (!if_reord.iIDCT_AFULL) begin
          w_emit = 1'b1;
          if (r_ridx == 6'd63) begin
            w_free     = 1'b1;
            w_rdst_nxt = R_IDLE;
          end
        end
      end
      default: w_rdst_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRSTN || iINIT) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_afull  <= 1'b0;
      r_wst    <= W_WAIT;
      r_pos    <= '0;
      r_wsel   <= 1'b0;
      r_rsel   <= 1'b0;
      r_bst[0] <= B_FREE;
      r_bst[1] <= B_FREE;
      r_mask   <= '0;
      r_rdst   <= R_IDLE;
      r_ridx   <= '0;
      r_co_en  <= 1'b0;
      r_co_lst <= 1'b0;
      r_co     <= '0;
      r_co_idx <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_afull <= (LP_DEPTH - w_cnt_nxt) <= LP_AOFF;

      r_wst <= w_wst_nxt;
      r_pos <= w_pos_nxt;
      if (w_claim) r_bst[r_wsel] <= B_FILL;
      if (w_done) begin
        r_bst[r_wsel] <= B_FULL;
        r_wsel        <= ~r_wsel;
      end
      if (w_wr) r_mask[r_wsel][w_nat] <= 1'b1;

      r_rdst <= w_rdst_nxt;
      if (w_emit) r_ridx <= r_ridx + 6'd1;
      if (w_free) begin
        r_bst[r_rsel]  <= B_FREE;
        r_mask[r_rsel] <= '0;
        r_rsel         <= ~r_rsel;
      end

      r_co_en  <= w_emit;
      r_co_lst <= w_emit && (r_ridx == 6'd63);
      if (w_emit) begin
        r_co_idx <= r_ridx;
        r_co     <= r_mask[r_rsel][r_ridx] ? r_mem[r_rsel][r_ridx] : 12'd0;
      end

      if (w_err || w_ovf) r_err <= 1'b1;
    end
  end

  // storage only; validity is tracked by the FIFO count and the bank masks
  always_ff @(posedge iCLK) begin
    if (w_push) r_fifo[r_wp] <= '{val: if_reord.iPI, dc: if_reord.iPI_DC,
                                  lst: if_reord.iPI_LST, zr: if_reord.iPI_ZR};
    if (w_wr)   r_mem[r_wsel][w_nat] <= w_head.val;
  end

  assign if_reord.oREORD_AFULL = r_afull;
  assign if_reord.oCO_EN       = r_co_en;
  assign if_reord.oCO          = r_co;
  assign if_reord.oCO_IDX      = r_co_idx;
  assign if_reord.oCO_LST      = r_co_lst;
  assign if_reord.oERR         = r_err;
endmodule

// File: tb/tb_jpeg_dec_reorder.sv
`timescale 1ns/1ps
module tb_jpeg_dec_reorder;
  typedef struct packed {
    logic [11:0] val;
    logic        dc;
    logic        lst;
    logic [3:0]  zr;
  } ent_t;

  typedef struct packed {
    logic [11:0] val;
    logic [5:0]  idx;
  } exp_t;

  logic iCLK  = 1'b0;
  logic iRSTN = 1'b0;
  logic iINIT = 1'b0;

  jpeg_dec_reorder_if bus();

  jpeg_dec_reorder #(.SKID_AW(2), .AFULL_OFF(2)) dut (
    .iCLK    (iCLK),
    .iRSTN   (iRSTN),
    .iINIT   (iINIT),
    .if_reord(bus)
  );

  always #5 iCLK = ~iCLK;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  ent_t cur[$];
  int   zz_nat[64];
  bit   exp_err  = 1'b0;
  bit   bp_en    = 1'b0;
  bit   force_af = 1'b0;
  bit   sat_en   = 1'b0;
  bit   saw_af   = 1'b0;
  bit   gap_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // zigzag order = walk the anti-diagonals, alternating direction
  function automatic void build_zz();
    int k;
    int lo;
    int hi;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zz_nat[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zz_nat[k] = r * 8 + (s - r); k++; end
      end
    end
  endfunction

  // reference: expand a block's entry list into a raster 8x8 block
  task automatic push_block(input ent_t q[$]);
    logic [11:0] blk [64];
    int  pos;
    int  tz;
    bit  stop;
    bit  err;
    for (int i = 0; i < 64; i++) blk[i] = 12'd0;
    pos  = 0;
    stop = 1'b0;
    err  = 1'b0;
    foreach (q[k]) begin
      if (!stop) begin
        tz = pos + int'(q[k].zr);
        if (tz > 63 || (q[k].dc && pos != 0) || (!q[k].dc && pos == 0)) begin
          err  = 1'b1;
          stop = 1'b1;
        end else begin
          blk[zz_nat[tz]] = q[k].val;
          pos = tz + 1;
          if (q[k].lst) stop = 1'b1;
          else if (pos == 64) begin err = 1'b1; stop = 1'b1; end
        end
      end
    end
    for (int r = 0; r < 64; r++) exp_q.push_back('{val: blk[r], idx: 6'(r)});
    if (err) exp_err = 1'b1;
  endtask

  // all driver tasks start and end at posedge+1
  task automatic drive_ent(input ent_t e);
    int g;
    g = 0;
    if (gap_en && $urandom_range(0, 3) == 0) begin @(posedge iCLK); #1; end
    while (bus.oREORD_AFULL && g < 2000) begin @(posedge iCLK); #1; g++; end
    if (g >= 2000) begin
      n_vec++; n_bad++;
      $display("FAIL afull_timeout: oREORD_AFULL stuck at 1, expected release");
    end
    bus.iPI_EN  = 1'b1;
    bus.iPI     = e.val;
    bus.iPI_DC  = e.dc;
    bus.iPI_LST = e.lst;
    bus.iPI_ZR  = e.zr;
    @(posedge iCLK); #1;
    bus.iPI_EN  = 1'b0;
  endtask

  task automatic send_cur(input bit check);
    if (check) push_block(cur);
    foreach (cur[k]) drive_ent(cur[k]);
  endtask

  task automatic gen_rand(input bit full);
    int pos;
    int zr;
    int mx;
    int tz;
    bit lst;
    cur.delete();
    pos = 0;
    for (int k = 0; k < 64; k++) begin
      if (k == 0 || full) zr = 0;
      else begin
        mx = 63 - pos;
        if (mx > 15) mx = 15;
        zr = int'($urandom_range(0, mx));
      end
      tz  = pos + zr;
      lst = (tz == 63) || (!full && $urandom_range(0, 11) == 0);
      cur.push_back('{val: 12'($urandom), dc: (k == 0), lst: lst, zr: 4'(zr)});
      pos = tz + 1;
      if (lst) break;
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 5000) begin @(posedge iCLK); #1; g++; end
    chk("drain_remaining", exp_q.size(), 0);
    repeat (3) begin @(posedge iCLK); #1; end
    chk("err_flag", bus.oERR, exp_err);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_co_en"}, bus.oCO_EN, 0);
    chk({tag, "_co"}, bus.oCO, 0);
    chk({tag, "_co_idx"}, bus.oCO_IDX, 0);
    chk({tag, "_co_lst"}, bus.oCO_LST, 0);
    chk({tag, "_afull"}, bus.oREORD_AFULL, 0);
    chk({tag, "_err"}, bus.oERR, 0);
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge iCLK);
      if (bus.oCO_EN === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_out: idx %0d val %0h, expected no output", bus.oCO_IDX, bus.oCO);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("co_val[%0d]", e.idx), bus.oCO, e.val);
          chk("co_idx", bus.oCO_IDX, e.idx);
          chk("co_lst", bus.oCO_LST, (e.idx == 6'd63));
        end
      end
    end
  end

  // IDCT backpressure source
  initial begin
    bus.iIDCT_AFULL = 1'b0;
    forever begin
      @(negedge iCLK);
      bus.iIDCT_AFULL = force_af | (bp_en & ($urandom_range(0, 1) == 1));
    end
  end

  initial begin
    forever begin
      @(negedge iCLK);
      if (sat_en && bus.oREORD_AFULL) saw_af = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    build_zz();
    bus.iPI_EN = 1'b0; bus.iPI = '0; bus.iPI_DC = 1'b0; bus.iPI_LST = 1'b0; bus.iPI_ZR = '0;
    repeat (3) @(posedge iCLK);
    #1;
    chk_idle("reset");
    iRSTN = 1'b1;
    @(posedge iCLK); #1;

    // single block: DC plus EOB, plus latency from last input
    cur.delete();
    cur.push_back('{val: 12'h05A, dc: 1'b1, lst: 1'b0, zr: 4'd0});
    cur.push_back('{val: 12'h003, dc: 1'b0, lst: 1'b1, zr: 4'd2});
    send_cur(1'b1);
    chk("lat_c1", bus.oCO_EN, 0);
    @(posedge iCLK); #1;
    chk("lat_c2", bus.oCO_EN, 0);
    @(posedge iCLK); #1;
    chk("lat_c3", bus.oCO_EN, 1);
    wait_drain();

    // full block in zigzag order, with an IDCT stall in the middle
    cur.delete();
    for (int k = 0; k < 64; k++)
      cur.push_back('{val: 12'(k), dc: (k == 0), lst: (k == 63), zr: 4'd0});
    send_cur(1'b1);
    g = 0;
    while (!bus.oCO_EN && g < 200) begin @(posedge iCLK); #1; g++; end
    chk("stall_start_seen", bus.oCO_EN, 1);
    force_af = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge iCLK); #1;
      chk("stall_no_out", bus.oCO_EN, 0);
    end
    force_af = 1'b0;
    wait_drain();

    // run overflow: pos 60 then ZR=5, block dropped through LST
    cur.delete();
    for (int k = 0; k < 60; k++)
      cur.push_back('{val: 12'(k + 100), dc: (k == 0), lst: 1'b0, zr: 4'd0});
    cur.push_back('{val: 12'h7FF, dc: 1'b0, lst: 1'b0, zr: 4'd5});
    cur.push_back('{val: 12'h123, dc: 1'b0, lst: 1'b0, zr: 4'd0});
    cur.push_back('{val: 12'h456, dc: 1'b0, lst: 1'b1, zr: 4'd0});
    send_cur(1'b1);
    gen_rand(1'b0);
    send_cur(1'b1);
    wait_drain();
    chk("err_sticky", bus.oERR, 1);
    gen_rand(1'b0);
    send_cur(1'b1);
    wait_drain();
    iINIT = 1'b1;
    @(posedge iCLK); #1;
    iINIT = 1'b0;
    exp_err = 1'b0;
    chk("err_cleared", bus.oERR, 0);

    // random blocks with random IDCT backpressure and random input gaps
    bp_en = 1'b1; sat_en = 1'b1; gap_en = 1'b1;
    for (int b = 0; b < 8; b++) begin
      gen_rand(b < 2);
      send_cur(1'b1);
    end
    wait_drain();
    bp_en = 1'b0; sat_en = 1'b0; gap_en = 1'b0;
    chk("afull_seen", saw_af, 1);

    // mid-block flush after 10 entries
    cur.delete();
    for (int k = 0; k < 10; k++)
      cur.push_back('{val: 12'(k + 12'h200), dc: (k == 0), lst: 1'b0, zr: 4'd0});
    send_cur(1'b0);
    iINIT = 1'b1;
    @(posedge iCLK); #1;
    iINIT = 1'b0;
    chk_idle("flush");
    cur.delete();
    cur.push_back('{val: 12'h9AB, dc: 1'b1, lst: 1'b0, zr: 4'd0});
    cur.push_back('{val: 12'h0CD, dc: 1'b0, lst: 1'b1, zr: 4'd15});
    send_cur(1'b1);
    wait_drain();

    // reset during an output burst at index 30
    gen_rand(1'b1);
    send_cur(1'b1);
    g = 0;
    while (g < 500) begin
      @(negedge iCLK);
      if (bus.oCO_EN && bus.oCO_IDX == 6'd30) break;
      g++;
    end
    chk("burst_idx30_seen", bus.oCO_IDX, 30);
    iRSTN = 1'b0;
    @(posedge iCLK); #1;
    chk("rst_co_en", bus.oCO_EN, 0);
    @(posedge iCLK); #1;
    exp_q.delete();
    exp_err = 1'b0;
    iRSTN = 1'b1;
    @(posedge iCLK); #1;
    chk("rst_afull", bus.oREORD_AFULL, 0);
    chk("rst_err", bus.oERR, 0);
    gen_rand(1'b0);
    send_cur(1'b1);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/jpeg_dec_reorder.md
# jpeg_dec_reorder

Zero-run expansion and de-zigzag stage of the JPEG decoder, directly downstream of the burst FIFO. It consumes run-length coefficient entries from the burst FIFO and assembles each 8x8 block into one bank of a 2-bank ping-pong coefficient buffer. Completed blocks are streamed to the IDCT in raster (natural) order, with implicit zeros filled in. Backpressure to the burst FIFO is provided on `oREORD_AFULL`.

## Interface
Parameters:
- `SKID_AW`, 2: address width of the input skid FIFO (depth 2**SKID_AW = 4).
- `AFULL_OFF`, 2: free-slot threshold for `oREORD_AFULL`, covering upstream reaction latency.

Ports (one clock; reset is synchronous and active-low; clock `iCLK`, reset `iRSTN`):
- `iCLK`  in  1  clock.
- `iRSTN`  in  1  synchronous active-low reset.
- `iINIT`  in  1  synchronous flush: same effect as reset, including clearing `oERR`.
- `iPI_EN`  in  1  entry valid from the burst FIFO.
- `iPI`  in  12  coefficient value (two's complement).
- `iPI_DC`  in  1  entry is the DC term (first entry of a block).
- `iPI_LST`  in  1  last entry of the block (EOB); remaining positions are zero.
- `iPI_ZR`  in  4  zeros preceding this coefficient in zigzag order.
- `oREORD_AFULL`  out  1  backpressure to the burst FIFO.
- `iIDCT_AFULL`  in  1  backpressure from the IDCT.
- `oCO_EN`  out  1  output coefficient valid.
- `oCO`  out  12  coefficient in raster order.
- `oCO_IDX`  out  6  raster index, 0..63.
- `oCO_LST`  out  1  high with `oCO_IDX`=63.
- `oERR`  out  1  sticky protocol error.

## Operation
- **Skid FIFO.** `iPI_EN` always writes the 4-entry skid FIFO; the producer must respect `oREORD_AFULL`. `oREORD_AFULL` = registered (free slots ≤ AFULL_OFF). A write while full is dropped and sets `oERR`.
- **Bank state.** Each bank has a 64×12 data array, a 64-bit written mask, and a state: FREE, FILL, or FULL. The write side owns at most one FILL bank; the read side drains FULL banks in completion order.
- **Write FSM.**
  - WAIT: a FREE bank exists and the skid FIFO is non-empty → claim the bank (state FILL), set pos=0, go to FILL.
  - FILL: pop one entry per cycle.
    - Target zigzag index is `tz = pos + ZR`, computed at 7 bits.
    - Write `mem[ZZ2NAT[tz]] <= iPI` and set the corresponding mask bit; then `pos <= tz + 1`.
    - On LST: bank becomes FULL; return to WAIT.
- **Error rules.** Each sets `oERR` and puts the FSM in DROP, which pops and discards entries up to and including the next LST, then marks the bank FULL:
  - `tz` > 63.
  - DC=1 with pos≠0.
  - DC=0 with pos=0.
  - pos reaches 64 without LST.
- **Read FSM.**
  - IDLE: oldest FULL bank exists and `iIDCT_AFULL`=0 → go to RUN with r=0.
  - RUN: emit one coefficient per cycle while `iIDCT_AFULL`=0; otherwise hold r.
    - `oCO = mask[r] ? mem[r] : 0`, `oCO_IDX = r`.
    - At r=63: clear the mask, set the bank FREE, return to IDLE.
- **ZZ2NAT.** Standard JPEG zigzag-to-natural table: 0,1,8,16,9,2,3,10,… 63.
- **Simultaneous events.** The write side may claim a bank in the same cycle the read side frees it: free takes effect first, so the claim succeeds one cycle later.
- **Flush.** Reset or `iINIT` clears the skid FIFO, both banks (FREE, mask=0), both FSMs, and `oERR`. An in-flight block is discarded.

## Timing
- **Reset values.** All outputs are 0 the cycle after `iRSTN`=0 or `iINIT`=1 is sampled.
- **Input path.** Entry sampled at cycle t is visible at the skid head at t+1. It is written to the bank at t+1 if the FSM is in FILL.
- **Block completion.** LST written at t → bank FULL at t+1 → first `oCO_EN` at t+2 if the read side is IDLE and `iIDCT_AFULL`=0.
- **Output is registered.** `iIDCT_AFULL`=1 at t means no `oCO_EN` at t+1. A 64-coefficient block takes 64 cycles when unstalled.
- **Throughput.** Sustained input of 1 entry/cycle is accepted while a bank is free. With both banks FULL or in read, `oREORD_AFULL` rises once free slots ≤ 2. Up to 2 further entries are absorbed without loss.
- **No bubbles.** There is no bubble between back-to-back blocks on the output when both banks are FULL.

## Test plan
- **Single block, DC plus EOB.** Input {0x05A, DC=1, LST=0, ZR=0}, {0x003, DC=0, LST=1, ZR=2}.
  - Output IDX0=0x05A.
  - zz2 maps to natural 8, so IDX8=0x003.
  - All other indices are 0; `oCO_LST` at IDX63.
  - First `oCO_EN` occurs 3 cycles after the last input.
- **Full block.** 64 entries with ZR=0, values 0..63 in zigzag order → output IDX r = NAT2ZZ[r] (IDX1=1, IDX8=2, IDX16=3).
- **Run overflow.** pos=60 then ZR=5 → `oERR`=1, block discarded through LST. The next block decodes correctly. `oERR` stays 1 until `iINIT`.
- **Backpressure.**
  - Random `iIDCT_AFULL` (50%) with 8 back-to-back blocks → no skid overflow, every block bit-exact, `oREORD_AFULL` asserted while both banks are busy.
  - Separately, `iIDCT_AFULL`=1 at t → no `oCO_EN` at t+1.
- **Mid-block flush.** Assert `iINIT` after 10 entries of a block → outputs 0 next cycle. A fresh block afterwards is emitted correctly, with no stale mask values.
- **Reset.** `iRSTN`=0 during an output burst at IDX 30 → `oCO_EN`=0 next cycle. After release, `oREORD_AFULL`=0 and `oERR`=0.
